csd_term_multiplier: RTL and testbench

Parametrised shift-add multiplier: multiplies an unsigned operand `a` by a constant given as up to `TERMS` signed power-of-two terms (canonical-signed-digit form), e.g. `a*(2^7 - 2^3 + 2^0)`. It accumulates one term per cycle. It generalises the two-term shift-add multiplier to `TERMS` terms, per-term signs and enables, and valid/ready handshakes on both sides with output backpressure. It sits in the datapath wherever constant/sparse-coefficient multiplies are needed.

---
 rtl/csd_mul_pkg.sv | 30 +++
 rtl/csd_term_addend.sv | 25 ++
 rtl/csd_term_multiplier.sv | 104 ++++++++++
 tb/tb_csd_term_multiplier.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/csd_mul_pkg.sv
// Shared types for the CSD term multiplier: FSM state encoding and the
// per-term descriptor (enable, sign, shift amount).
package csd_mul_pkg;

  // Shift-amount field width in the term descriptor. Callers with a narrower
  // exponent index zero-extend into it, so any N <= CSD_IDX_N is supported.
  localparam int unsigned CSD_IDX_N = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } csd_state_e;

  typedef struct packed {
    logic                 en;
    logic                 neg;
    logic [CSD_IDX_N-1:0] idx;
  } csd_term_t;

  function automatic csd_term_t csd_make_term(input logic en, input logic neg,
                                              input logic [CSD_IDX_N-1:0] idx);
    csd_term_t t;
    t.en  = en;
    t.neg = neg;
    t.idx = idx;
    return t;
  endfunction

endpackage

// File: rtl/csd_term_addend.sv
// Combinational addend for one CSD term: +/-(a << idx) in 2*A_N bits, or 0
// when the term is disabled.
module csd_term_addend
  import csd_mul_pkg::*;
#(
  parameter int unsigned A_N = 16
) (
  input  logic [A_N-1:0]   a,
  input  csd_term_t        term,
  output logic [2*A_N-1:0] addend
);

  logic [2*A_N-1:0] a_ext;
  logic [2*A_N-1:0] shifted;

  always_comb begin
    a_ext   = {{A_N{1'b0}}, a};
    shifted = a_ext << term.idx;
    addend  = '0;
    if (term.en) begin
      addend = term.neg ? -shifted : shifted;
    end
  end

endmodule

// File: rtl/csd_term_multiplier.sv
// Shift-add multiplier by a sparse signed power-of-two constant; one term is
// accumulated per cycle with valid/ready handshakes on both sides.
module csd_term_multiplier
  import csd_mul_pkg::*;
#(
  parameter int unsigned A_N   = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned TERMS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [A_N-1:0]     a,
  input  logic [TERMS-1:0]   term_en,
  input  logic [TERMS-1:0]   term_neg,
  input  logic [TERMS*N-1:0] term_idx,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [2*A_N-1:0]   c
);

  localparam int unsigned CW = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CW-1:0] LAST_TERM = CW'(TERMS - 1);

  csd_state_e       state;
  logic [CW-1:0]    cnt;
  logic [A_N-1:0]   a_q;
  csd_term_t        terms_q [TERMS];
  logic [2*A_N-1:0] acc;
  logic [2*A_N-1:0] c_q;
  logic [2*A_N-1:0] addend;
  logic [2*A_N-1:0] acc_next;
  csd_term_t        cur_term;
  logic             accept;

  assign in_rdy  = (state == IDLE) || ((state == DONE) && out_rdy);
  assign accept  = in_vld && in_rdy;
  assign out_vld = (state == DONE);
  assign c       = c_q;

  always_comb begin
    cur_term = terms_q[cnt];
  end

  csd_term_addend #(
    .A_N (A_N)
  ) u_addend (
    .a      (a_q),
    .term   (cur_term),
    .addend (addend)
  );

  assign acc_next = acc + addend;

  // Accept is handled outside the state case so IDLE and the back-to-back
  // DONE path share one capture point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      acc   <= '0;
      c_q   <= '0;
      for (int unsigned i = 0; i < TERMS; i++) begin
        terms_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_TERM) begin
            c_q   <= acc_next;
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state <= in_vld ? ACCUM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        a_q <= a;
        acc <= '0;
        cnt <= '0;
        for (int unsigned i = 0; i < TERMS; i++) begin
          terms_q[i] <= csd_make_term(term_en[i], term_neg[i],
                                      CSD_IDX_N'(term_idx[i*N +: N]));
        end
      end
    end
  end

endmodule

// File: tb/tb_csd_term_multiplier.sv
// Directed self-checking bench for csd_term_multiplier (A_N=16, N=4, TERMS=4).
module tb_csd_term_multiplier;

  localparam int unsigned A_N   = 16;
  localparam int unsigned N     = 4;
  localparam int unsigned TERMS = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_vld = 1'b0;
  logic                 in_rdy;
  logic [A_N-1:0]       a = '0;
  logic [TERMS-1:0]     term_en = '0;
  logic [TERMS-1:0]     term_neg = '0;
  logic [TERMS*N-1:0]   term_idx = '0;
  logic                 out_vld;
  logic                 out_rdy = 1'b0;
  logic [2*A_N-1:0]     c;

  int checks = 0;
  int errors = 0;

  csd_term_multiplier #(
    .A_N   (A_N),
    .N     (N),
    .TERMS (TERMS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .a        (a),
    .term_en  (term_en),
    .term_neg (term_neg),
    .term_idx (term_idx),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .c        (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int i0, input int i1, input int i2, input int i3);
    return {4'(i3), 4'(i2), 4'(i1), 4'(i0)};
  endfunction

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!in_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) check({tag, "_rdy_wait"}, 64'(in_rdy), 64'd1);
  endtask

  // Present a request, hold it for the accept edge, then scramble the inputs.
  task automatic send(input logic [15:0] aa, input logic [3:0] en, input logic [3:0] neg,
                      input logic [15:0] idx);
    a = aa; term_en = en; term_neg = neg; term_idx = idx; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    a = 16'($urandom); term_en = 4'($urandom); term_neg = 4'($urandom);
    term_idx = 16'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int cyc = 0;
    while (!out_vld && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(TERMS));
    check({tag, "_c"}, 64'(c), 64'(exp));
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] aa, input logic [3:0] en,
                        input logic [3:0] neg, input logic [15:0] idx,
                        input logic [31:0] exp);
    wait_rdy(tag);
    send(aa, en, neg, idx);
    wait_result(tag, exp);
    consume();
  endtask

  function automatic logic [31:0] term_val(input logic [15:0] aa, input int idx, input bit neg);
    logic [31:0] v;
    v = {16'd0, aa} << idx;
    return neg ? (32'd0 - v) : v;
  endfunction

  initial begin
    logic [31:0] bp_c;
    logic [31:0] e;

    #12;
    check("reset_out_vld", 64'(out_vld), 64'd0);
    check("reset_in_rdy", 64'(in_rdy), 64'd1);
    check("reset_c", 64'(c), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // out_rdy with nothing pending must be ignored
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy_out_vld", 64'(out_vld), 64'd0);
    check("idle_rdy_in_rdy", 64'(in_rdy), 64'd1);
    out_rdy = 1'b0;

    run_op("a5", 16'd5, 4'b0011, 4'b0000, pk(2, 0, 0, 0), 32'd25);
    check("after_consume_idle", 64'(in_rdy), 64'd1);
    run_op("a100", 16'd100, 4'b0011, 4'b0010, pk(4, 2, 0, 0), 32'd1200);
    run_op("neg3", 16'd3, 4'b0001, 4'b0001, pk(0, 0, 0, 0), 32'hFFFF_FFFD);
    // 4 * 0xFFFF * 2^15 = 0x1_FFFE_0000, wraps to 0xFFFE_0000
    run_op("wrap", 16'hFFFF, 4'b1111, 4'b0000, pk(15, 15, 15, 15), 32'hFFFE_0000);
    run_op("all_off", 16'hABCD, 4'b0000, 4'b1111, pk(7, 3, 1, 9), 32'd0);
    run_op("slot3", 16'd11, 4'b1000, 4'b0000, pk(0, 0, 0, 3), 32'd88);

    // Backpressure then back-to-back accept from DONE
    wait_rdy("bp");
    send(16'd9, 4'b0001, 4'b0000, pk(3, 0, 0, 0));
    wait_result("bp1", 32'd72);
    bp_c = c;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_c", 64'(c), 64'(bp_c));
      check("bp_hold_vld", 64'(out_vld), 64'd1);
      check("bp_hold_in_rdy", 64'(in_rdy), 64'd0);
    end
    a = 16'd10; term_en = 4'b0011; term_neg = 4'b0010; term_idx = pk(1, 0, 0, 0);
    in_vld = 1'b1; out_rdy = 1'b1;
    #1;
    check("b2b_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;
    in_vld = 1'b0; out_rdy = 1'b0;
    a = 16'hFFFF; term_en = 4'b1111;
    check("b2b_vld_drop", 64'(out_vld), 64'd0);
    wait_result("bp2", 32'd10);
    consume();

    // Reset in the middle of an accumulation
    wait_rdy("rst");
    send(16'd500, 4'b1111, 4'b0000, pk(8, 8, 8, 8));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst", 16'd7, 4'b0001, 4'b0000, pk(1, 0, 0, 0), 32'd14);

    // Sweep: single terms and two-term pairs (slots 1 and 3) for a < 16
    for (int av = 0; av < 16; av++) begin
      for (int i = 0; i < 16; i++) begin
        for (int s = 0; s < 2; s++) begin
          e = term_val(16'(av), i, s[0]);
          run_op("sweep1", 16'(av), 4'b0001, {3'b000, s[0]}, pk(i, 0, 0, 0), e);
        end
      end
      for (int i = 0; i < 16; i++) begin
        for (int j = i + 1; j < 16; j++) begin
          for (int s = 0; s < 4; s++) begin
            e = term_val(16'(av), i, s[0]) + term_val(16'(av), j, s[1]);
            run_op("sweep2", 16'(av), 4'b1010, {s[1], 1'b0, s[0], 1'b0},
                   pk(0, i, 0, j), e);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
